// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the arbiter. The arbiter uses the
// master modport; the requesters and the uart_tx model use the slave modport.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_par_en;
  logic [N_REQ-1:0]   req_par_typ;
  logic [N_REQ-1:0]   req_ack;
  logic [7:0]         tx_p_data;
  logic               tx_data_valid;
  logic               tx_par_en;
  logic               tx_par_typ;
  logic               tx_busy;

  modport master (
    input  req_valid, req_data, req_par_en, req_par_typ, tx_busy,
    output req_ack, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ
  );

  modport slave (
    output req_valid, req_data, req_par_en, req_par_typ, tx_busy,
    input  req_ack, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte requesters.
// Captures the winner's byte and parity settings, launches, then tracks Busy.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_arbiter_if.master        bus,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active,
  output logic                     frame_done,
  output logic                     timeout_err
);
  localparam int GID_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [GID_W-1:0] GID_MAX  = GID_W'(N_REQ - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [GID_W-1:0] last_grant;
  logic [CNT_W-1:0] busy_cnt;
  logic [GID_W-1:0] win_idx;
  logic             win_found;
  logic [GID_W-1:0] cand;

  // Search starts one past the last served requester and wraps at N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = last_grant;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == GID_MAX) ? '0 : cand + GID_W'(1);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (win_found && !bus.tx_busy) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)               state_nxt = WAIT_DONE;
        else if (busy_cnt == CNT_LAST) state_nxt = IDLE;
      end
      WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Registered outputs; pulses default low and are raised for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      last_grant        <= GID_MAX;
      busy_cnt          <= '0;
      grant_id          <= '0;
      active            <= 1'b0;
      frame_done        <= 1'b0;
      timeout_err       <= 1'b0;
      bus.req_ack       <= '0;
      bus.tx_p_data     <= 8'h00;
      bus.tx_data_valid <= 1'b0;
      bus.tx_par_en     <= 1'b0;
      bus.tx_par_typ    <= 1'b0;
    end else begin
      state             <= state_nxt;
      active            <= (state_nxt != IDLE);
      bus.req_ack       <= '0;
      bus.tx_data_valid <= 1'b0;
      frame_done        <= 1'b0;
      timeout_err       <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nxt == LAUNCH) begin
            bus.req_ack    <= N_REQ'(1) << win_idx;
            bus.tx_p_data  <= bus.req_data[{win_idx, 3'b000} +: 8];
            bus.tx_par_en  <= bus.req_par_en[win_idx];
            bus.tx_par_typ <= bus.req_par_typ[win_idx];
            grant_id       <= win_idx;
          end
        end
        LAUNCH: begin
          bus.tx_data_valid <= 1'b1;
          busy_cnt          <= '0;
        end
        WAIT_BUSY: begin
          if (!bus.tx_busy) begin
            busy_cnt <= busy_cnt + CNT_W'(1);
            if (busy_cnt == CNT_LAST) begin
              timeout_err <= 1'b1;
              last_grant  <= grant_id;
            end
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            frame_done <= 1'b1;
            last_grant <= grant_id;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
